// File: rtl/reg_file_if.sv
// reg_file_if: decoder read ports, ROB rename/commit ports and status of the register file.
interface reg_file_if;
    logic        rdy;
    logic        jp_wrong;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [3:0]  rs1_idx;
    logic [3:0]  rs2_idx;
    logic        upd_flag;
    logic [3:0]  upd_idx;
    logic [4:0]  upd_rd;
    logic        write_flag;
    logic [3:0]  write_idx;
    logic [4:0]  write_rd;
    logic [31:0] new_val;
    logic [31:0] commit_cnt;

    modport master (
        output rdy, jp_wrong, rs1, rs2, upd_flag, upd_idx, upd_rd,
               write_flag, write_idx, write_rd, new_val,
        input  rs1_busy, rs2_busy, rs1_val, rs2_val, rs1_idx, rs2_idx, commit_cnt
    );

    modport slave (
        input  rdy, jp_wrong, rs1, rs2, upd_flag, upd_idx, upd_rd,
               write_flag, write_idx, write_rd, new_val,
        output rs1_busy, rs2_busy, rs1_val, rs2_val, rs1_idx, rs2_idx, commit_cnt
    );
endinterface

// File: rtl/reg_file.sv
// reg_file: 32x32 architectural registers with ROB busy/tag tracking and commit counter.
// Optional macro REGFILE_BYPASS_EN forwards a matching same-cycle commit to the read ports.
module reg_file (
    input  logic   clk,
    input  logic   rst,
    reg_file_if.slave bus
);
    logic [31:0] val_q [32];
    logic [31:0] val_d [32];
    logic [3:0]  tag_q [32];
    logic [3:0]  tag_d [32];
    logic [31:0] busy_q, busy_d;
    logic [31:0] cnt_q, cnt_d;
    logic        byp1, byp2;

    always_comb begin
        val_d  = val_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (bus.rdy) begin
            if (bus.write_flag && bus.write_rd != 5'd0) begin
                val_d[bus.write_rd] = bus.new_val;
                cnt_d = cnt_q + 32'd1;
                // a younger rename owns the register when the tag differs
                if (tag_q[bus.write_rd] == bus.write_idx) busy_d[bus.write_rd] = 1'b0;
            end
            if (bus.jp_wrong) begin
                busy_d = '0;
            end else if (bus.upd_flag && bus.upd_rd != 5'd0) begin
                busy_d[bus.upd_rd] = 1'b1;
                tag_d[bus.upd_rd]  = bus.upd_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q  <= '{default: '0};
            tag_q  <= '{default: '0};
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            val_q  <= val_d;
            tag_q  <= tag_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
`ifdef REGFILE_BYPASS_EN
        byp1 = bus.write_flag && bus.rs1 != 5'd0 && bus.write_rd == bus.rs1 && tag_q[bus.rs1] == bus.write_idx;
        byp2 = bus.write_flag && bus.rs2 != 5'd0 && bus.write_rd == bus.rs2 && tag_q[bus.rs2] == bus.write_idx;
`else
        byp1 = 1'b0;
        byp2 = 1'b0;
`endif
    end

    assign bus.rs1_val    = byp1 ? bus.new_val : val_q[bus.rs1];
    assign bus.rs2_val    = byp2 ? bus.new_val : val_q[bus.rs2];
    assign bus.rs1_busy   = byp1 ? 1'b0 : busy_q[bus.rs1];
    assign bus.rs2_busy   = byp2 ? 1'b0 : busy_q[bus.rs2];
    assign bus.rs1_idx    = tag_q[bus.rs1];
    assign bus.rs2_idx    = tag_q[bus.rs2];
    assign bus.commit_cnt = cnt_q;
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed scoreboard bench for reg_file.
module tb_reg_file;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];

    reg_file_if bus();
    reg_file dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #10 clk = ~clk;

    function automatic logic [31:0] obs(int sel);
        case (sel)
            0: return bus.rs1_val;
            1: return {31'd0, bus.rs1_busy};
            2: return {28'd0, bus.rs1_idx};
            3: return bus.rs2_val;
            4: return {31'd0, bus.rs2_busy};
            5: return {28'd0, bus.rs2_idx};
            default: return bus.commit_cnt;
        endcase
    endfunction

    task automatic ex(string t, int sel, logic [31:0] v);
        sb.push_back('{t, sel, v});
    endtask

    task automatic drain();
        exp_t e;
        logic [31:0] o;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sel);
            total++;
            assert (o === e.v) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", e.tag, o, e.v);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.rdy = 1'b1;
        bus.jp_wrong = 1'b0;
        bus.upd_flag = 1'b0;
        bus.write_flag = 1'b0;
    endtask

    task automatic upd(logic [4:0] rd, logic [3:0] idx);
        bus.upd_flag = 1'b1;
        bus.upd_rd = rd;
        bus.upd_idx = idx;
    endtask

    task automatic wr(logic [4:0] rd, logic [3:0] idx, logic [31:0] v);
        bus.write_flag = 1'b1;
        bus.write_rd = rd;
        bus.write_idx = idx;
        bus.new_val = v;
    endtask

    initial begin
        bus.rdy = 1'b1;
        bus.jp_wrong = 1'b0;
        bus.rs1 = '0;
        bus.rs2 = '0;
        bus.upd_flag = 1'b0;
        bus.upd_idx = '0;
        bus.upd_rd = '0;
        bus.write_flag = 1'b0;
        bus.write_idx = '0;
        bus.write_rd = '0;
        bus.new_val = '0;
        tick();
        tick();
        rst = 1'b0;
        bus.rs1 = 5'd0;
        bus.rs2 = 5'd31;
        ex("rst_rs1_val", 0, 0); ex("rst_rs1_busy", 1, 0); ex("rst_rs1_idx", 2, 0);
        ex("rst_rs2_val", 3, 0); ex("rst_rs2_busy", 4, 0); ex("rst_rs2_idx", 5, 0);
        ex("rst_cnt", 6, 0);
        drain();

        upd(5'd5, 4'd3);
        tick();
        bus.rs1 = 5'd5;
        ex("ren_x5_busy", 1, 1); ex("ren_x5_idx", 2, 3);
        drain();
        wr(5'd5, 4'd3, 32'hDEADBEEF);
        tick();
        ex("cmt_x5_busy", 1, 0); ex("cmt_x5_val", 0, 32'hDEADBEEF); ex("cmt_cnt1", 6, 1);
        drain();

        upd(5'd7, 4'd2);
        tick();
        upd(5'd7, 4'd9);
        tick();
        wr(5'd7, 4'd2, 32'h11);
        tick();
        bus.rs1 = 5'd7;
        ex("stale_x7_val", 0, 32'h11); ex("stale_x7_busy", 1, 1); ex("stale_x7_idx", 2, 9);
        ex("stale_cnt", 6, 2);
        drain();

        upd(5'd4, 4'd1);
        tick();
        upd(5'd4, 4'd6);
        wr(5'd4, 4'd1, 32'h55);
        tick();
        bus.rs1 = 5'd4;
        ex("same_x4_val", 0, 32'h55); ex("same_x4_busy", 1, 1); ex("same_x4_idx", 2, 6);
        ex("same_cnt", 6, 3);
        drain();

        upd(5'd1, 4'd1);
        tick();
        upd(5'd2, 4'd2);
        tick();
        upd(5'd3, 4'd3);
        tick();
        bus.rs1 = 5'd1;
        bus.rs2 = 5'd3;
        ex("pre_x1_busy", 1, 1); ex("pre_x3_busy", 4, 1);
        drain();
        bus.jp_wrong = 1'b1;
        upd(5'd9, 4'd4);
        wr(5'd10, 4'd0, 32'h77);
        tick();
        ex("flush_x1_busy", 1, 0); ex("flush_x3_busy", 4, 0);
        drain();
        bus.rs1 = 5'd9;
        bus.rs2 = 5'd7;
        ex("flush_x9_busy", 1, 0); ex("flush_x9_idx", 2, 0); ex("flush_x7_busy", 4, 0);
        drain();
        bus.rs1 = 5'd10;
        bus.rs2 = 5'd4;
        ex("flush_x10_val", 0, 32'h77); ex("flush_x4_busy", 4, 0); ex("flush_cnt", 6, 4);
        drain();

        upd(5'd0, 4'd7);
        wr(5'd0, 4'd0, 32'hFFFFFFFF);
        tick();
        bus.rs1 = 5'd0;
        ex("x0_val", 0, 0); ex("x0_busy", 1, 0); ex("x0_idx", 2, 0); ex("x0_cnt", 6, 4);
        drain();

        bus.rdy = 1'b0;
        wr(5'd8, 4'd0, 32'h88);
        upd(5'd6, 4'd5);
        tick();
        bus.rs1 = 5'd8;
        bus.rs2 = 5'd6;
        ex("hold_x8_val", 0, 0); ex("hold_x6_busy", 4, 0); ex("hold_x6_idx", 5, 0);
        ex("hold_cnt", 6, 4);
        drain();

        upd(5'd5, 4'd3);
        tick();
        wr(5'd5, 4'd3, 32'hAB);
        upd(5'd5, 4'd8);
        bus.rs2 = 5'd5;
`ifdef REGFILE_BYPASS_EN
        ex("byp_rs2_val", 3, 32'hAB); ex("byp_rs2_busy", 4, 0);
`else
        ex("nobyp_rs2_busy", 4, 1); ex("nobyp_rs2_idx", 5, 3); ex("nobyp_rs2_val", 3, 32'hDEADBEEF);
`endif
        drain();
        tick();
        ex("post_x5_val", 3, 32'hAB); ex("post_x5_busy", 4, 1); ex("post_x5_idx", 5, 8);
        ex("post_cnt", 6, 5);
        drain();

        rst = 1'b1;
        bus.rdy = 1'b0;
        upd(5'd5, 4'd2);
        wr(5'd5, 4'd8, 32'h99);
        tick();
        rst = 1'b0;
        ex("rst2_x5_val", 3, 0); ex("rst2_x5_busy", 4, 0); ex("rst2_x5_idx", 5, 0);
        ex("rst2_cnt", 6, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL: rst  input  1  synchronous reset, active-high.
REQ-003 SHALL: rdy  input  1  global enable; low = hold all state.
REQ-004 SHALL: jp_wrong  input  1  misprediction flush from ROB.
REQ-005 SHALL: rs1, rs2  input  5 each  source register numbers from Decoder.
REQ-006 SHALL: rs1_busy, rs2_busy  output  1 each  source awaits an in-flight ROB result.
REQ-007 SHALL: rs1_val, rs2_val  output  32 each  architectural register values.
REQ-008 SHALL: rs1_idx, rs2_idx  output  4 each  ROB tag of the pending producer, to ROB.
REQ-009 SHALL: upd_flag  input  1, upd_idx  input  4, upd_rd  input  5: rename from ROB, meaning rd now produced by ROB entry upd_idx.
REQ-010 SHALL: write_flag  input  1, write_idx  input  4, write_rd  input  5, new_val  input  32: commit from ROB.
REQ-011 SHALL: commit_cnt  output  32  count of committed register writes.

Function
REQ-012 SHALL hold 32 x 32-bit values, 32 busy bits and 32 4-bit tags.
REQ-013 SHALL treat x0 as hardwired: val 0, busy 0, tag 0; writes and renames to rd=0 are ignored.
REQ-014 SHALL drive rsN_val = val[rsN], rsN_busy = busy[rsN] and rsN_idx = tag[rsN] combinationally.
REQ-015 SHALL, on a cycle with upd_flag=1 and upd_rd!=0, set busy[upd_rd]=1 and tag[upd_rd]=upd_idx at the next edge.
REQ-016 SHALL, on a cycle with write_flag=1 and write_rd!=0, write val[write_rd]=new_val and increment commit_cnt by 1 (wrapping mod 2^32).
REQ-017 SHALL clear busy[write_rd] on commit only when tag[write_rd]==write_idx; on a tag mismatch a younger producer owns the register and busy stays set.
REQ-018 SHALL give rename priority when upd_rd==write_rd in the same cycle: the value is written, busy ends 1 and the tag ends upd_idx.
REQ-019 SHALL, with jp_wrong=1, clear all 32 busy bits, ignore upd_flag that cycle, and still apply a same-cycle commit value write and count increment.
REQ-020 SHALL, with rdy=0 and rst=0, leave all state and commit_cnt unchanged regardless of other inputs.
REQ-021 SHALL complete update latency in exactly one cycle; reads in the cycle after an update see the new state.

Reset
REQ-022 SHALL, on rst=1 at posedge, set all values to 0, all busy bits to 0, all tags to 0 and commit_cnt to 0; rst overrides rdy, jp_wrong and all update inputs.
REQ-023 SHALL, after reset, drive rsN_busy=0, rsN_val=0 and rsN_idx=0 for every rsN.

Configuration
REQ-024 SHALL support macro REGFILE_BYPASS_EN.
- Defined: when write_flag=1, write_rd==rsN!=0 and tag[rsN]==write_idx, rsN_val=new_val and rsN_busy=0 combinationally in the same cycle. A same-cycle rename of rsN does not affect the read.
- Undefined: reads reflect registered state only. The ROB supplies the ready value via the tag.

Verification
REQ-025 SHALL cover: after reset, rename x5->tag 3 -> next cycle rs1=5 gives busy=1, idx=3; commit x5 tag 3, val 0xDEADBEEF -> busy=0, val=0xDEADBEEF, commit_cnt=1.
REQ-026 SHALL cover: rename x7->tag 2, then rename x7->tag 9, then commit x7 tag 2 val 0x11 -> val=0x11, busy=1, idx=9.
REQ-027 SHALL cover: same-cycle rename x4->tag 6 and commit x4 (tag 1 owner) val 0x55 -> val=0x55, busy=1, idx=6.
REQ-028 SHALL cover: busy x1, x2, x3 then jp_wrong=1 with upd x9 -> all busy=0, x9 not busy.
REQ-029 SHALL cover: write_rd=0 val 0xFFFFFFFF -> x0 reads 0; rdy=0 with commit x8 -> no change, commit_cnt unchanged.
REQ-030 SHALL cover: with REGFILE_BYPASS_EN, x5 busy tag 3 and commit x5 tag 3 val 0xAB while rs2=5 -> same cycle rs2_val=0xAB, rs2_busy=0; without the macro -> rs2_busy=1, rs2_idx=3.
